// File: rtl/tone_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tone_decoder
// Brief    : Measures the half-period of a square-wave tone and reports stable notes.
// Revision : 1.0
// ============================================================================
module tone_decoder #(
    parameter int PRESCALE      = 2048,
    parameter int TIMEOUT_UNITS = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       audio,
    output logic [6:0] hp_meas,
    output logic       hp_valid,
    output logic [6:0] note_hp,
    output logic       note_stb,
    output logic       tone_active
);

    localparam int CNT_MAX = TIMEOUT_UNITS * PRESCALE;
    localparam int CW      = $clog2(CNT_MAX + 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    hp_meas_q, hp_meas_d;
    logic          hp_valid_q, hp_valid_d;
    logic [6:0]    note_hp_q, note_hp_d;
    logic          note_stb_q, note_stb_d;
    logic          tone_active_q, tone_active_d;
    logic [6:0]    prev_q, prev_d;
    logic          prev_valid_q, prev_valid_d;
    logic          noted_q, noted_d;

    logic          edge_w;
    logic          timeout_w;
    logic [CW:0]   n_round_w;
    logic [CW:0]   raw_full_w;
    logic [6:0]    raw_w;

    // sync_q[1] is the synchronized sample, sync_q[2] its value one cycle earlier
    assign edge_w     = sync_q[2] ^ sync_q[1];
    assign timeout_w  = (state_q != IDLE) && (cnt_q == CW'(CNT_MAX - 1));
    // cnt_q lags the true elapsed cycle count by one
    assign n_round_w  = {1'b0, cnt_q} + (CW+1)'(1 + PRESCALE / 2);
    assign raw_full_w = n_round_w / (CW+1)'(PRESCALE);
    assign raw_w      = (raw_full_w > (CW+1)'(127)) ? 7'd127 : raw_full_w[6:0];

    always_comb begin
        state_d       = state_q;
        sync_d        = {sync_q[1:0], audio};
        hp_meas_d     = hp_meas_q;
        hp_valid_d    = 1'b0;
        note_hp_d     = note_hp_q;
        note_stb_d    = 1'b0;
        tone_active_d = tone_active_q;
        prev_d        = prev_q;
        prev_valid_d  = prev_valid_q;
        noted_d       = noted_q;

        if (edge_w) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(CNT_MAX)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        if (edge_w) begin
            if (state_q == IDLE || timeout_w) begin
                // an edge coincident with timeout becomes the new reference edge
                state_d = ARMED;
                if (timeout_w) begin
                    tone_active_d = 1'b0;
                    prev_valid_d  = 1'b0;
                    noted_d       = 1'b0;
                end
            end else if (raw_w != 7'd0) begin
                state_d    = LOCKED;
                hp_meas_d  = raw_w;
                hp_valid_d = 1'b1;
                if (prev_valid_q && (raw_w == prev_q) &&
                    (!noted_q || (raw_w != note_hp_q))) begin
                    note_hp_d     = raw_w;
                    note_stb_d    = 1'b1;
                    tone_active_d = 1'b1;
                    noted_d       = 1'b1;
                end
                prev_d       = raw_w;
                prev_valid_d = 1'b1;
            end
        end else if (timeout_w) begin
            state_d       = IDLE;
            tone_active_d = 1'b0;
            prev_valid_d  = 1'b0;
            noted_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            sync_q        <= '0;
            cnt_q         <= '0;
            hp_meas_q     <= '0;
            hp_valid_q    <= 1'b0;
            note_hp_q     <= '0;
            note_stb_q    <= 1'b0;
            tone_active_q <= 1'b0;
            prev_q        <= '0;
            prev_valid_q  <= 1'b0;
            noted_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            cnt_q         <= cnt_d;
            hp_meas_q     <= hp_meas_d;
            hp_valid_q    <= hp_valid_d;
            note_hp_q     <= note_hp_d;
            note_stb_q    <= note_stb_d;
            tone_active_q <= tone_active_d;
            prev_q        <= prev_d;
            prev_valid_q  <= prev_valid_d;
            noted_q       <= noted_d;
        end
    end

    assign hp_meas     = hp_meas_q;
    assign hp_valid    = hp_valid_q;
    assign note_hp     = note_hp_q;
    assign note_stb    = note_stb_q;
    assign tone_active = tone_active_q;

endmodule
`default_nettype wire

// File: doc/tone_decoder.md
TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 2048, giving the clk cycles per half-period unit, which equals one synth tick of the audio engine.
REQ-002 The block SHALL have parameter TIMEOUT_UNITS, default 128, giving the number of half-period units without an edge after which the input is declared silent.
REQ-003 The block SHALL have port clk, input, width 1, the single clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1, an asynchronous, active-high reset.
REQ-005 The block SHALL have port audio, input, width 1, the square-wave tone stream, asynchronous to clk.
REQ-006 The block SHALL have port hp_meas, output, width 7, the most recent measured half-period in units.
REQ-007 The block SHALL have port hp_valid, output, width 1, a one-cycle strobe when hp_meas updates.
REQ-008 The block SHALL have port note_hp, output, width 7, the last confirmed (stable) half-period.
REQ-009 The block SHALL have port note_stb, output, width 1, a one-cycle strobe when note_hp updates.
REQ-010 The block SHALL have port tone_active, output, width 1, high while a tone is being tracked.

Function
REQ-011 audio SHALL pass through a 2-flop synchronizer; an edge is any change between synchronized samples on consecutive cycles.
REQ-012 An elapsed-cycle counter SHALL clear on each detected edge and increment on every other cycle, saturating at TIMEOUT_UNITS*PRESCALE.
REQ-013 On each edge, with N equal to the elapsed cycles since the previous edge, the raw measurement SHALL be floor((N + PRESCALE/2)/PRESCALE), saturated to 127.
REQ-014 The FSM SHALL have states IDLE (no reference edge), ARMED (reference edge seen, no valid measurement yet) and LOCKED (at least one valid measurement).
REQ-015 In IDLE, an edge SHALL transition to ARMED with no measurement produced.
REQ-016 In ARMED or LOCKED, an edge with a raw measurement of at least 1 SHALL load hp_meas, pulse hp_valid on the following cycle, and go to LOCKED.
REQ-017 An edge with a raw measurement of 0 (glitch, N < PRESCALE/2) SHALL be discarded: no strobe, state unchanged, elapsed counter still cleared.
REQ-018 In ARMED or LOCKED, the elapsed counter reaching TIMEOUT_UNITS*PRESCALE SHALL force IDLE, clear tone_active, and invalidate the stability history; hp_meas and note_hp SHALL hold their values.
REQ-019 If a timeout and an edge occur on the same cycle, the edge SHALL take priority and be treated as the IDLE-entry edge, giving ARMED.
REQ-020 Stability check: when a new measurement equals the previous valid measurement since the last IDLE exit, and differs from note_hp or is the first since IDLE, the block SHALL load note_hp and pulse note_stb in the same cycle as hp_valid.
REQ-021 tone_active SHALL rise with the first note_stb after IDLE and fall only on timeout or reset.
REQ-022 hp_valid and note_stb SHALL never be high for more than one consecutive cycle.
REQ-023 The outputs SHALL be registered, with no combinational path from audio to any output.

Reset
REQ-024 While rst is asserted, all outputs, the synchronizer, the counters and the history SHALL be 0 and the FSM SHALL be in IDLE.
REQ-025 rst SHALL take effect immediately (asynchronously), including mid-measurement; after deassertion, the first edge only arms the block.

Verification (PRESCALE=16, TIMEOUT_UNITS=128)
REQ-026 A bench SHALL cover steady tone: audio toggling every 752 cycles -> edge 2 gives hp_valid with hp_meas=47; edge 3 gives hp_valid, note_stb, note_hp=47 and tone_active=1.
REQ-027 A bench SHALL cover rounding: edge spacings of 759 and 760 cycles -> hp_meas of 47 and 48 respectively.
REQ-028 A bench SHALL cover note change: spacing 752, 752, 1120, 1120 -> note_hp goes 47 then 70, with exactly two note_stb pulses, and no note_stb on the first 1120 edge.
REQ-029 A bench SHALL cover silence: toggling stops after lock -> tone_active=0 exactly 2048 cycles after the last synchronized edge; the next edge produces no hp_valid.
REQ-030 A bench SHALL cover glitch: a 3-cycle pulse inside a 752-cycle tone -> glitch edges discarded and no hp_meas below 1.
REQ-031 A bench SHALL cover reset mid-operation: rst asserted for 1 cycle while LOCKED -> all outputs 0 immediately, and 2 further edges are needed before hp_valid.
